multi_lane_issue_queue: RTL and testbench
=========================================

Name: multi_lane_issue_queue

Overview:
Parametrised superscalar issue queue: the successor to the fixed three-pipeline instruction queue. It accepts instruction bursts of 1..MAX_COPY copies for any of NUM_LANES execution lanes and places each burst on a shared virtual timeline. Placement respects per-lane occupancy and the completion latency of the previously pushed lane. Each pop releases one timeline slot to every lane at once. The block sits between the instruction decoder and the DMA, regfile and math pipelines. New relative to the predecessor:
- Modular position arithmetic, so there is no needs_reset and no timeline exhaustion.
- Ready/valid backpressure on push.
- Per-lane burst-descriptor FIFOs with bounded depth.
- Lane count, payload width and latencies are set by parameters.

Parameters:
NUM_LANES, 3, number of execution lanes (lane 0 = DMA, 1 = load/store, 2 = arithmetic by convention)
PAYLOAD_W, 40, per-burst payload bits, zero-padded for narrower lanes
MAX_COPY, 16, maximum copies per burst; also the lane reservation stride
POS_BITS, 16, width of the modular timeline position
DESC_DEPTH, 8, burst descriptors held per lane (power of 2)
LANE_LATENCY, {4'd10,4'd3,4'd2}, packed 4-bit completion latency per lane, lane 0 in the LSBs

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  in  1  push request
in_ready  out  1  push accepted this cycle when in_valid and in_ready are both high
in_lane  in  $clog2(NUM_LANES)  target lane
in_copy_count  in  $clog2(MAX_COPY)+1  burst length, 1..MAX_COPY
in_payload  in  PAYLOAD_W  instruction fields, including base and delta addresses
re  in  1  advance the timeline one slot
out_valid  out  NUM_LANES  lane issues a copy this slot
out_payload  out  NUM_LANES*PAYLOAD_W  burst payload of the issuing copy, per lane
out_first  out  NUM_LANES  copy index is 0 (new superscalar group)
out_index  out  NUM_LANES*$clog2(MAX_COPY)  copy index within the burst
empty  out  1  no descriptor is pending in any lane

Behaviour:
- Reset state (asynchronous, reset low): all outputs 0, except empty=1 and in_ready=1. All positions 0, FIFOs empty, prev_lane=0.
- Modular compare: a is "later than" b iff (a-b) mod 2^POS_BITS is in the range 1..2^(POS_BITS-1)-1. max3 is built from this compare.
- Insert position: ins = max3(done_pos[prev_lane], next_free[in_lane], read_pos).
- On accept:
  - push the descriptor {ins, in_copy_count, in_payload} into FIFO[in_lane]
  - done_pos[in_lane] <= ins + LANE_LATENCY[in_lane]
  - next_free[in_lane] <= ins + MAX_COPY
  - prev_lane <= in_lane
- in_ready is low when any of these holds:
  - FIFO[in_lane] is full
  - (ins - read_pos) mod 2^POS_BITS >= 2^(POS_BITS-1) - MAX_COPY (window guard)
  - in_copy_count is 0 or greater than MAX_COPY
- When in_valid is high and in_ready is low: no state changes. The push is not retried internally.
- Pop (re=1): read_pos <= read_pos + 1, wrapping mod 2^POS_BITS. For each lane, at the next edge (1-cycle latency):
  - out_valid=1 iff the head descriptor satisfies 0 <= read_pos - pos < count.
  - out_index = read_pos - pos; out_first = (out_index == 0).
  - When out_index = count-1, the head is popped in the same cycle.
- re=0: all out_valid bits go to 0 at the next edge; out_payload holds its previous value.
- A head descriptor whose pos is later than read_pos waits and produces out_valid=0 (gap slot).
- Simultaneous push and pop in the same cycle:
  - ins uses the pre-pop read_pos.
  - A push to a lane whose head is popping that cycle sees the freed slot: FIFO full is evaluated after the pop.
- empty = all FIFOs empty. A pop while empty still advances read_pos, and every out_valid is 0.
- Wrap-around: positions crossing 2^POS_BITS-1 to 0 compare correctly. No reset or stall is required.
- Reset asserted mid-burst: all state clears immediately and the partially issued burst is discarded.

Decomposition:
- Shared package iq_pkg holds:
  - lane index constants LANE_DMA/LANE_LDST/LANE_ARITH
  - the default LANE_LATENCY
  - the descriptor typedef
  - a pos_later(a,b) function
- One sub-module, lane_desc_fifo:
  - distributed-RAM FIFO of descriptors, depth DESC_DEPTH
  - full/empty flags, head peek, pop
  - instantiated NUM_LANES times via generate

Test Plan:
- After reset: push lane 1, count 4, payload 0xA; then re for 5 cycles -> lane1 out_valid=1 for 4 cycles, out_index 0,1,2,3, out_first only on the first; empty=1 after the 4th.
- Push lane 0 (count 2), then lane 2 (count 1) -> lane 2 placed at ins = 0+LANE_LATENCY[0] = 2; with re held high, lane2 valid only in slot 2.
- Push 8 bursts to lane 2 with re=0 -> in_ready=0 on the 9th; re for 1 slot frees nothing (head pos 2 not reached); head retires at slot 2, and in_ready=1 in that same cycle.
- Preload read_pos near 0xFFFE, push count 4 -> issues at 0xFFFE, 0xFFFF, 0x0000, 0x0001 with out_index 0..3 and no stall.
- in_copy_count = 0 or 17 -> in_ready=0, no FIFO change.
- Assert reset (low) while out_index=1 -> all out_valid=0 immediately, empty=1; later pushes start at pos 0.

Source files
------------

// File: rtl/iq_pkg.sv
// Shared lane constants, descriptor layout and modular timeline compare
// for the multi-lane issue queue.
package iq_pkg;

  localparam int LANE_DMA   = 0;
  localparam int LANE_LDST  = 1;
  localparam int LANE_ARITH = 2;

  localparam int POS_W = 16;
  localparam int CNT_W = 5;
  localparam int PAY_W = 40;

  localparam logic [11:0] LANE_LATENCY_DEF = {4'd10, 4'd3, 4'd2};

  typedef struct packed {
    logic [POS_W-1:0] pos;
    logic [CNT_W-1:0] cnt;
    logic [PAY_W-1:0] payload;
  } desc_t;

  // a is later than b when their distance on the ring is in the lower half.
  function automatic logic pos_later(
    input logic [31:0] a,
    input logic [31:0] b,
    input int unsigned bits
  );
    logic [31:0] m;
    logic [31:0] d;
    m = (32'd1 << bits) - 32'd1;
    d = (a - b) & m;
    return (d != 32'd0) && (d < (32'd1 << (bits - 1)));
  endfunction

endpackage

// File: rtl/lane_desc_fifo.sv
// Per-lane burst-descriptor FIFO with combinational head peek.
// Push and pop may coincide even when full.
module lane_desc_fifo #(
  parameter int W     = 61,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_wdata,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr[AW-1:0]] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + ONE;
      if (i_pop)  r_rd <= r_rd + ONE;
    end
  end

  assign o_head  = r_mem[r_rd[AW-1:0]];
  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);

endmodule

// File: rtl/multi_lane_issue_queue.sv
// Superscalar issue queue: places bursts on a modular timeline and
// releases one slot per pop to every lane.
module multi_lane_issue_queue
  import iq_pkg::*;
#(
  parameter int NUM_LANES  = 3,
  parameter int PAYLOAD_W  = PAY_W,
  parameter int MAX_COPY   = 16,
  parameter int POS_BITS   = POS_W,
  parameter int DESC_DEPTH = 8,
  parameter logic [4*NUM_LANES-1:0] LANE_LATENCY = LANE_LATENCY_DEF
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [$clog2(NUM_LANES)-1:0]         in_lane,
  input  logic [$clog2(MAX_COPY):0]            in_copy_count,
  input  logic [PAYLOAD_W-1:0]                 in_payload,
  input  logic                                 re,
  output logic [NUM_LANES-1:0]                 out_valid,
  output logic [NUM_LANES*PAYLOAD_W-1:0]       out_payload,
  output logic [NUM_LANES-1:0]                 out_first,
  output logic [NUM_LANES*$clog2(MAX_COPY)-1:0] out_index,
  output logic                                 empty
);

  localparam int LW = $clog2(NUM_LANES);
  localparam int CW = $clog2(MAX_COPY) + 1;
  localparam int IW = $clog2(MAX_COPY);
  localparam int DW = POS_BITS + CW + PAYLOAD_W;

  typedef logic [POS_BITS-1:0] pos_t;
  typedef struct packed {
    pos_t                 pos;
    logic [CW-1:0]        cnt;
    logic [PAYLOAD_W-1:0] pay;
  } ldesc_t;

  localparam pos_t WIN = pos_t'(2 ** (POS_BITS - 1) - MAX_COPY);
  localparam pos_t STRIDE = pos_t'(MAX_COPY);
  localparam logic [CW-1:0] MAXC = CW'(MAX_COPY);

  function automatic logic later(pos_t a, pos_t b);
    return pos_later(32'(a), 32'(b), POS_BITS);
  endfunction

  pos_t                 r_read;
  pos_t                 r_done [NUM_LANES];
  pos_t                 r_free [NUM_LANES];
  logic [LW-1:0]        r_prev;

  ldesc_t               w_head [NUM_LANES];
  ldesc_t               w_new;
  pos_t                 w_idx  [NUM_LANES];
  logic [NUM_LANES-1:0] w_full;
  logic [NUM_LANES-1:0] w_empty;
  logic [NUM_LANES-1:0] w_hit;
  logic [NUM_LANES-1:0] w_pop;
  logic [NUM_LANES-1:0] w_push;
  pos_t                 w_m;
  pos_t                 w_ins;
  logic                 w_lane_ok;
  logic                 w_cnt_ok;
  logic                 w_win_ok;
  logic                 w_blocked;
  logic                 w_acc;

  // A head issues while read_pos lies inside [pos, pos+cnt).
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      w_idx[l] = r_read - w_head[l].pos;
      w_hit[l] = re && !w_empty[l] &&
                 (w_idx[l] < pos_t'(w_head[l].cnt));
      w_pop[l] = w_hit[l] &&
                 (w_idx[l] == pos_t'(w_head[l].cnt) - pos_t'(1));
      w_push[l] = w_acc && (32'(in_lane) == l);
    end
  end

  always_comb begin
    w_m = later(r_done[r_prev], r_free[in_lane]) ?
          r_done[r_prev] : r_free[in_lane];
    w_ins = later(r_read, w_m) ? r_read : w_m;
  end

  assign w_lane_ok = 32'(in_lane) < NUM_LANES;
  assign w_win_ok  = (w_ins - r_read) < WIN;
  assign w_cnt_ok  = (in_copy_count != '0) && (in_copy_count <= MAXC);
  assign w_blocked = w_lane_ok && w_full[in_lane] && !w_pop[in_lane];
  assign in_ready  = w_win_ok && !w_blocked &&
                     (!in_valid || (w_lane_ok && w_cnt_ok));
  assign w_acc     = in_valid && in_ready;
  assign w_new     = '{pos: w_ins, cnt: in_copy_count, pay: in_payload};
  assign empty     = &w_empty;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_desc_fifo #(
      .W     (DW),
      .DEPTH (DESC_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .i_push  (w_push[g]),
      .i_pop   (w_pop[g]),
      .i_wdata (w_new),
      .o_head  (w_head[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_read      <= '0;
      r_prev      <= LW'(LANE_DMA);
      out_valid   <= '0;
      out_first   <= '0;
      out_index   <= '0;
      out_payload <= '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        r_done[l] <= '0;
        r_free[l] <= '0;
      end
    end else begin
      if (re) r_read <= r_read + pos_t'(1);
      if (w_acc) r_prev <= in_lane;
      for (int l = 0; l < NUM_LANES; l++) begin
        if (w_push[l]) begin
          r_done[l] <= w_ins + pos_t'(LANE_LATENCY[4*l +: 4]);
          r_free[l] <= w_ins + STRIDE;
        end
        out_valid[l] <= w_hit[l];
        out_first[l] <= w_hit[l] && (w_idx[l] == '0);
        if (w_hit[l]) begin
          out_index[l*IW +: IW] <= w_idx[l][IW-1:0];
          out_payload[l*PAYLOAD_W +: PAYLOAD_W] <= w_head[l].pay;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_lane_issue_queue.sv
// Bench for multi_lane_issue_queue: directed scenarios plus random
// traffic, all scored against a queue-based timeline model.
module tb_multi_lane_issue_queue;
  import iq_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_lane;
  logic [4:0]   in_copy_count;
  logic [39:0]  in_payload;
  logic         re;
  logic [2:0]   out_valid;
  logic [119:0] out_payload;
  logic [2:0]   out_first;
  logic [11:0]  out_index;
  logic         empty;

  multi_lane_issue_queue dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_lane       (in_lane),
    .in_copy_count (in_copy_count),
    .in_payload    (in_payload),
    .re            (re),
    .out_valid     (out_valid),
    .out_payload   (out_payload),
    .out_first     (out_first),
    .out_index     (out_index),
    .empty         (empty)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference timeline: plain positions and per-lane descriptor queues.
  int          lat [3] = '{2, 3, 10};
  logic [15:0] m_read;
  logic [15:0] m_done [3];
  logic [15:0] m_free [3];
  logic [1:0]  m_prev;
  desc_t       m_q [3][$];
  bit          e_valid [3];
  bit          e_first [3];
  logic [3:0]  e_index [3];
  logic [39:0] e_pay [3];

  function automatic bit m_later(logic [15:0] a, logic [15:0] b);
    logic [15:0] d;
    d = a - b;
    return (d != 16'd0) && (d < 16'h8000);
  endfunction

  function automatic logic [15:0] m_max3(logic [15:0] a, logic [15:0] b,
                                         logic [15:0] c);
    logic [15:0] m;
    m = m_later(a, b) ? a : b;
    return m_later(c, m) ? c : m;
  endfunction

  task automatic m_reset();
    m_read = '0;
    m_prev = '0;
    for (int l = 0; l < 3; l++) begin
      m_done[l] = '0;
      m_free[l] = '0;
      m_q[l].delete();
      e_valid[l] = 0;
      e_first[l] = 0;
    end
  endtask

  task automatic do_reset();
    in_valid = 0; in_lane = 0; in_copy_count = 0;
    in_payload = 0; re = 0;
    reset = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask

  task automatic step(input logic v, input logic [1:0] ln,
                      input logic [4:0] cn, input logic [39:0] pl,
                      input logic r, output logic rdy);
    logic [15:0] ins;
    logic [15:0] idx [3];
    bit          hit [3];
    bit          pop [3];
    bit          exp_rdy;
    bit          exp_empty;
    in_valid = v; in_lane = ln; in_copy_count = cn;
    in_payload = pl; re = r;
    exp_empty = 1;
    for (int l = 0; l < 3; l++) begin
      hit[l] = 0; pop[l] = 0; idx[l] = '0;
      if (m_q[l].size() > 0) begin
        exp_empty = 0;
        idx[l] = m_read - m_q[l][0].pos;
        hit[l] = r && (idx[l] < 16'(m_q[l][0].cnt));
        pop[l] = hit[l] && (idx[l] == 16'(m_q[l][0].cnt) - 16'd1);
      end
    end
    ins = m_max3(m_done[m_prev], m_free[ln], m_read);
    exp_rdy = (m_q[ln].size() - (pop[ln] ? 1 : 0) < 8) &&
              (16'(ins - m_read) < 16'h7FF0) &&
              (!v || (cn >= 1 && cn <= 16));
    @(negedge clk);
    rdy = in_ready;
    chk("in_ready", in_ready, exp_rdy);
    chk("empty", empty, exp_empty);
    @(posedge clk);
    for (int l = 0; l < 3; l++) begin
      e_valid[l] = hit[l];
      e_first[l] = hit[l] && (idx[l] == 16'd0);
      if (hit[l]) begin
        e_index[l] = idx[l][3:0];
        e_pay[l] = m_q[l][0].payload;
      end
      if (pop[l]) void'(m_q[l].pop_front());
    end
    if (v && exp_rdy) begin
      m_q[ln].push_back('{pos: ins, cnt: cn, payload: pl});
      m_done[ln] = ins + 16'(lat[ln]);
      m_free[ln] = ins + 16'd16;
      m_prev = ln;
    end
    if (r) m_read = m_read + 16'd1;
    #1;
    for (int l = 0; l < 3; l++) begin
      chk($sformatf("valid%0d", l), out_valid[l], e_valid[l]);
      chk($sformatf("first%0d", l), out_first[l], e_first[l]);
      if (e_valid[l]) begin
        chk($sformatf("index%0d", l), out_index[l*4 +: 4], e_index[l]);
        chk($sformatf("payload%0d", l), out_payload[l*40 +: 40],
            e_pay[l]);
      end
    end
  endtask

  task automatic idle_re(input int n);
    logic rd;
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 1, rd);
  endtask

  logic        rd;
  logic [1:0]  r_ln;
  logic [4:0]  r_cn;
  logic [39:0] r_pl;

  initial begin
    do_reset();
    chk("rst_valid", out_valid, 3'b000);
    chk("rst_first", out_first, 3'b000);
    chk("rst_index", out_index, 12'h000);
    chk("rst_payload", out_payload[63:0], 64'h0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_ready", in_ready, 1'b1);

    // Single burst of four on load/store.
    step(1, 2'(LANE_LDST), 5'd4, 40'hA, 0, rd);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, '0, 1, rd);
      if (k < 4) begin
        chk("t1_valid", out_valid[1], 1'b1);
        chk("t1_index", out_index[7:4], 4'(k));
        chk("t1_first", out_first[1], k == 0);
      end
      if (k == 3) chk("t1_empty", empty, 1'b1);
    end

    // Arithmetic burst waits for the DMA latency.
    do_reset();
    step(1, 2'(LANE_DMA), 5'd2, 40'h11, 0, rd);
    step(1, 2'(LANE_ARITH), 5'd1, 40'h22, 0, rd);
    for (int s = 0; s < 4; s++) begin
      step(0, 0, 0, '0, 1, rd);
      chk("t2_slot", out_valid[2], s == 2);
    end

    // Fill the arithmetic FIFO, then free it by retiring the head.
    do_reset();
    step(1, 2'(LANE_DMA), 5'd2, 40'h33, 0, rd);
    for (int i = 0; i < 8; i++)
      step(1, 2'(LANE_ARITH), 5'd1, 40'(i), 0, rd);
    step(1, 2'(LANE_ARITH), 5'd1, 40'h99, 0, rd);
    chk("t3_full", rd, 1'b0);
    for (int s = 0; s < 3; s++) begin
      step(1, 2'(LANE_ARITH), 5'd1, 40'h77, 1, rd);
      chk("t3_ready", rd, s == 2);
    end

    // Illegal burst lengths.
    do_reset();
    step(1, 1, 5'd0, 40'h1, 0, rd);
    chk("cnt0_ready", rd, 1'b0);
    step(1, 1, 5'd17, 40'h1, 0, rd);
    chk("cnt17_ready", rd, 1'b0);
    chk("badcnt_empty", empty, 1'b1);

    // Reset in the middle of a burst.
    do_reset();
    step(1, 2'(LANE_ARITH), 5'd4, 40'hBEEF, 0, rd);
    step(0, 0, 0, '0, 1, rd);
    step(0, 0, 0, '0, 1, rd);
    chk("mid_index", out_index[11:8], 4'd1);
    in_valid = 0; re = 0;
    reset = 0;
    #1;
    chk("mid_valid", out_valid, 3'b000);
    chk("mid_empty", empty, 1'b1);
    m_reset();
    @(posedge clk);
    #1 reset = 1;
    step(1, 2'(LANE_DMA), 5'd1, 40'h55, 0, rd);
    step(0, 0, 0, '0, 1, rd);
    chk("post_valid", out_valid[0], 1'b1);
    chk("post_index", out_index[3:0], 4'd0);

    // Walk the timeline across the wrap point.
    do_reset();
    idle_re(16'h7000);
    step(1, 1, 5'd1, 40'h70, 0, rd);
    idle_re(16'hC000 - 16'h7000);
    step(1, 1, 5'd1, 40'hC0, 0, rd);
    idle_re(16'hFFFE - 16'hC000);
    step(1, 1, 5'd4, 40'hFE, 0, rd);
    chk("wrap_ready", rd, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, '0, 1, rd);
      chk("wrap_valid", out_valid[1], 1'b1);
      chk("wrap_index", out_index[7:4], 4'(k));
    end

    // Random mixed traffic.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      r_ln = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0)
        r_cn = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd17;
      else
        r_cn = 5'($urandom_range(1, 16));
      r_pl = {8'($urandom), $urandom};
      step(1'($urandom_range(0, 1)), r_ln, r_cn, r_pl,
           1'($urandom_range(0, 99) < 55), rd);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
